// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - UART command framer: sync hunt, frame assembly, ACK/NAK response, error count
//
// Consumes bytes from the uart receiver, hunts for SYNC_BYTE, then assembles
// OPCODE, LEN, LEN payload bytes and a check byte. A good frame is presented
// on the CMD_* valid/ready interface and answered with ACK_BYTE; a bad check
// byte or an oversize LEN is answered with NAK_BYTE. Inter-byte silence of
// TIMEOUT_CYCLES drops the frame without a response. NAKs and timeouts bump
// a saturating ERR_COUNT.
//
// Build option: define UART_FRAME_CRC8_EN to use a CRC-8 (poly 0x07, init 0,
// MSB-first, no final XOR) check byte instead of the XOR checksum.
//
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   RX_DONE, RX_BUFFER    received byte strobe and data from uart
//   RX_TRIGGER            receive enable to uart (framer accepting bytes)
//   TX_DONE               uart finished sending the response byte
//   TX_TRIGGER, TX_BUFFER one-cycle send strobe and response byte
//   CMD_VALID, CMD_READY  command handshake to the tester core
//   CMD_OPCODE, CMD_LEN   command opcode and payload byte count
//   CMD_PAYLOAD           payload, byte i at [8i+7:8i], unused bytes zero
//   ERR_COUNT             saturating NAK/timeout counter

module uart_frame_rx #(
    parameter int         MAX_PAYLOAD    = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter logic [7:0] ACK_BYTE       = 8'h06,
    parameter logic [7:0] NAK_BYTE       = 8'h15,
    parameter int         TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     RX_DONE,
    input  logic [7:0]               RX_BUFFER,
    output logic                     RX_TRIGGER,
    input  logic                     TX_DONE,
    output logic                     TX_TRIGGER,
    output logic [7:0]               TX_BUFFER,
    output logic                     CMD_VALID,
    input  logic                     CMD_READY,
    output logic [7:0]               CMD_OPCODE,
    output logic [3:0]               CMD_LEN,
    output logic [8*MAX_PAYLOAD-1:0] CMD_PAYLOAD,
    output logic [7:0]               ERR_COUNT
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = 8 * MAX_PAYLOAD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPC,
        S_LEN,
        S_PAY,
        S_CHK,
        S_RESP,
        S_HOLD
    } state_t;

    // Fold one byte into the running check value.
    function automatic logic [7:0] acc_update(input logic [7:0] acc, input logic [7:0] b);
`ifdef UART_FRAME_CRC8_EN
        logic [7:0] c;
        c = acc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
`else
        return acc ^ b;
`endif
    endfunction

    state_t          state_q, state_d;
    logic [7:0]      acc_q, acc_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [3:0]      idx_q, idx_d;
    logic [7:0]      opcode_q, opcode_d;
    logic [3:0]      len_q, len_d;
    logic [PW-1:0]   payload_q, payload_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic [7:0]      tx_buf_q, tx_buf_d;
    logic            tx_trig_q, tx_trig_d;
    logic [7:0]      err_q, err_d;
    logic            rx_trigger_q, rx_trigger_d;

    logic            rx_ok;
    logic            handshake;
    logic            counting;
    logic            timeout;
    logic            resp_go;
    logic            resp_nak;
    logic            err_inc;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        tmo_d        = '0;
        idx_d        = idx_q;
        opcode_d     = opcode_q;
        len_d        = len_q;
        payload_d    = payload_q;
        cmd_valid_d  = cmd_valid_q;
        tx_buf_d     = tx_buf_q;
        tx_trig_d    = 1'b0;
        err_d        = err_q;
        rx_trigger_d = 1'b0;
        resp_go      = 1'b0;
        resp_nak     = 1'b0;
        err_inc      = 1'b0;

        // Bytes are only taken while the uart has been told we are listening;
        // the registered enable is what the uart actually sees.
        rx_ok     = RX_DONE && rx_trigger_q;
        handshake = cmd_valid_q && CMD_READY;
        if (handshake) begin
            cmd_valid_d = 1'b0;
        end

        counting = (state_q == S_OPC) || (state_q == S_LEN) ||
                   (state_q == S_PAY) || (state_q == S_CHK);
        if (counting && !rx_ok) begin
            tmo_d = tmo_q + 1'b1;
        end
        // A byte arriving on the expiry cycle wins over the timeout.
        timeout = counting && !rx_ok && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

        case (state_q)
            S_IDLE: begin
                if (rx_ok && (RX_BUFFER == SYNC_BYTE)) begin
                    state_d   = S_OPC;
                    payload_d = '0;
                    acc_d     = 8'h00;
                end
            end
            S_OPC: begin
                if (rx_ok) begin
                    opcode_d = RX_BUFFER;
                    acc_d    = acc_update(acc_q, RX_BUFFER);
                    state_d  = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_ok) begin
                    acc_d = acc_update(acc_q, RX_BUFFER);
                    if (RX_BUFFER > 8'(MAX_PAYLOAD)) begin
                        resp_go  = 1'b1;
                        resp_nak = 1'b1;
                    end else begin
                        len_d   = RX_BUFFER[3:0];
                        idx_d   = 4'd0;
                        state_d = (RX_BUFFER == 8'h00) ? S_CHK : S_PAY;
                    end
                end
            end
            S_PAY: begin
                if (rx_ok) begin
                    for (int i = 0; i < MAX_PAYLOAD; i++) begin
                        if (idx_q == 4'(i)) begin
                            payload_d[8*i +: 8] = RX_BUFFER;
                        end
                    end
                    acc_d = acc_update(acc_q, RX_BUFFER);
                    idx_d = idx_q + 4'd1;
                    if ((idx_q + 4'd1) == len_q) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (rx_ok) begin
                    resp_go = 1'b1;
                    if (RX_BUFFER == acc_q) begin
                        cmd_valid_d = 1'b1;
                    end else begin
                        resp_nak = 1'b1;
                    end
                end
            end
            S_RESP: begin
                // A NAK never has a command pending, so the post-handshake
                // valid alone decides between HOLD and IDLE.
                if (TX_DONE) begin
                    state_d = cmd_valid_d ? S_HOLD : S_IDLE;
                end
            end
            S_HOLD: begin
                if (handshake) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (timeout) begin
            state_d = S_IDLE;
            err_inc = 1'b1;
        end

        if (resp_go) begin
            state_d   = S_RESP;
            tx_trig_d = 1'b1;
            tx_buf_d  = resp_nak ? NAK_BYTE : ACK_BYTE;
            if (resp_nak) begin
                err_inc = 1'b1;
            end
        end

        if (err_inc && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end

        rx_trigger_d = (state_d == S_IDLE) || (state_d == S_OPC) ||
                       (state_d == S_LEN)  || (state_d == S_PAY) ||
                       (state_d == S_CHK);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            acc_q        <= 8'h00;
            tmo_q        <= '0;
            idx_q        <= 4'd0;
            opcode_q     <= 8'h00;
            len_q        <= 4'd0;
            payload_q    <= '0;
            cmd_valid_q  <= 1'b0;
            tx_buf_q     <= 8'h00;
            tx_trig_q    <= 1'b0;
            err_q        <= 8'h00;
            rx_trigger_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            tmo_q        <= tmo_d;
            idx_q        <= idx_d;
            opcode_q     <= opcode_d;
            len_q        <= len_d;
            payload_q    <= payload_d;
            cmd_valid_q  <= cmd_valid_d;
            tx_buf_q     <= tx_buf_d;
            tx_trig_q    <= tx_trig_d;
            err_q        <= err_d;
            rx_trigger_q <= rx_trigger_d;
        end
    end

    assign RX_TRIGGER  = rx_trigger_q;
    assign TX_TRIGGER  = tx_trig_q;
    assign TX_BUFFER   = tx_buf_q;
    assign CMD_VALID   = cmd_valid_q;
    assign CMD_OPCODE  = opcode_q;
    assign CMD_LEN     = len_q;
    assign CMD_PAYLOAD = payload_q;
    assign ERR_COUNT   = err_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - scoreboard bench for uart_frame_rx (XOR build)

module tb_uart_frame_rx;

    typedef struct packed {
        logic [7:0]  op;
        logic [3:0]  len;
        logic [63:0] pl;
    } cmd_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RX_DONE = 1'b0;
    logic [7:0]  RX_BUFFER = 8'h00;
    logic        RX_TRIGGER;
    logic        TX_DONE = 1'b0;
    logic        TX_TRIGGER;
    logic [7:0]  TX_BUFFER;
    logic        CMD_VALID;
    logic        CMD_READY = 1'b1;
    logic [7:0]  CMD_OPCODE;
    logic [3:0]  CMD_LEN;
    logic [63:0] CMD_PAYLOAD;
    logic [7:0]  ERR_COUNT;

    int total = 0;
    int bad = 0;
    int exp_err = 0;

    logic [7:0] exp_tx[$];
    cmd_t       exp_cmd[$];
    logic [7:0] seq[$];

    uart_frame_rx #(
        .MAX_PAYLOAD(8),
        .SYNC_BYTE(8'hA5),
        .ACK_BYTE(8'h06),
        .NAK_BYTE(8'h15),
        .TIMEOUT_CYCLES(5000)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .RX_DONE(RX_DONE),
        .RX_BUFFER(RX_BUFFER),
        .RX_TRIGGER(RX_TRIGGER),
        .TX_DONE(TX_DONE),
        .TX_TRIGGER(TX_TRIGGER),
        .TX_BUFFER(TX_BUFFER),
        .CMD_VALID(CMD_VALID),
        .CMD_READY(CMD_READY),
        .CMD_OPCODE(CMD_OPCODE),
        .CMD_LEN(CMD_LEN),
        .CMD_PAYLOAD(CMD_PAYLOAD),
        .ERR_COUNT(ERR_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response byte
    // or completes a command handshake.
    initial begin
        cmd_t c;
        logic [7:0] t;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (TX_TRIGGER) begin
                    if (exp_tx.size() == 0) begin
                        chk("unexpected_tx_trigger", {56'h0, TX_BUFFER}, 64'hFFFF);
                    end else begin
                        t = exp_tx.pop_front();
                        chk("tx_buffer", {56'h0, TX_BUFFER}, {56'h0, t});
                    end
                end
                if (CMD_VALID && CMD_READY) begin
                    if (exp_cmd.size() == 0) begin
                        chk("unexpected_cmd", {56'h0, CMD_OPCODE}, 64'hFFFF);
                    end else begin
                        c = exp_cmd.pop_front();
                        chk("cmd_opcode", {56'h0, CMD_OPCODE}, {56'h0, c.op});
                        chk("cmd_len", {60'h0, CMD_LEN}, {60'h0, c.len});
                        chk("cmd_payload", CMD_PAYLOAD, c.pl);
                    end
                end
            end
        end
    end

    // Uart transmit side: finishes each response byte a fixed time later.
    initial begin
        forever begin
            @(negedge CLK);
            if (TX_TRIGGER && !RST) begin
                repeat (10) @(posedge CLK);
                #1 TX_DONE = 1'b1;
                @(posedge CLK);
                #1 TX_DONE = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK);
        #1;
        RX_BUFFER = b;
        RX_DONE   = 1'b1;
        @(posedge CLK);
        #1;
        RX_DONE   = 1'b0;
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_byte(seq[i]);
    endtask

    task automatic push_cmd(input logic [7:0] op, input logic [3:0] len, input logic [63:0] pl);
        cmd_t c;
        c.op  = op;
        c.len = len;
        c.pl  = pl;
        exp_cmd.push_back(c);
    endtask

    task automatic add_err();
        if (exp_err < 255) exp_err++;
    endtask

    task automatic settle(input string name);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_cmd.size() != 0) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        chk({name, "_drain"}, 64'(exp_tx.size() + exp_cmd.size()), 64'd0);
        repeat (30) @(negedge CLK);
        chk({name, "_err"}, {56'h0, ERR_COUNT}, 64'(exp_err));
    endtask

    task automatic reset_checks(input string name);
        chk({name, "_rxt"}, {63'h0, RX_TRIGGER}, 64'd0);
        chk({name, "_txt"}, {63'h0, TX_TRIGGER}, 64'd0);
        chk({name, "_txb"}, {56'h0, TX_BUFFER}, 64'd0);
        chk({name, "_valid"}, {63'h0, CMD_VALID}, 64'd0);
        chk({name, "_op"}, {56'h0, CMD_OPCODE}, 64'd0);
        chk({name, "_len"}, {60'h0, CMD_LEN}, 64'd0);
        chk({name, "_pl"}, CMD_PAYLOAD, 64'd0);
        chk({name, "_err"}, {56'h0, ERR_COUNT}, 64'd0);
    endtask

    initial begin
        int vcnt, rcnt, dcnt;

        // Reset state
        repeat (2) @(negedge CLK);
        reset_checks("reset");
        @(posedge CLK);
        #1 RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("idle_rx_trigger", {63'h0, RX_TRIGGER}, 64'd1);

        // Good frame
        exp_tx.push_back(8'h06);
        push_cmd(8'h10, 4'd2, 64'h2211);
        seq = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
        send_seq();
        settle("good");

        // Bad checksum, then a good frame
        exp_tx.push_back(8'h15);
        add_err();
        seq = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20};
        send_seq();
        settle("badchk");
        exp_tx.push_back(8'h06);
        push_cmd(8'h20, 4'd1, 64'h7F);
        seq = '{8'hA5, 8'h20, 8'h01, 8'h7F, 8'h5E};
        send_seq();
        settle("after_bad");

        // Zero-length frame behind junk
        exp_tx.push_back(8'h06);
        push_cmd(8'h33, 4'd0, 64'h0);
        seq = '{8'h00, 8'hFF, 8'h33, 8'hA5, 8'h33, 8'h00, 8'h33};
        send_seq();
        settle("zero_len");

        // Maximum-length frame
        exp_tx.push_back(8'h06);
        push_cmd(8'h01, 4'd8, 64'h0807060504030201);
        seq = '{8'hA5, 8'h01, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04,
                8'h05, 8'h06, 8'h07, 8'h08, 8'h01};
        send_seq();
        settle("max_len");

        // Oversize LEN
        exp_tx.push_back(8'h15);
        add_err();
        seq = '{8'hA5, 8'h10, 8'h09};
        send_seq();
        settle("oversize");

        // Timeout: expires on the 5000th idle cycle after the last byte
        seq = '{8'hA5, 8'h10};
        send_seq();
        repeat (4999) @(posedge CLK);
        #1 chk("tmo_before", {56'h0, ERR_COUNT}, 64'(exp_err));
        @(posedge CLK);
        add_err();
        #1 chk("tmo_at", {56'h0, ERR_COUNT}, 64'(exp_err));
        settle("timeout");

        // Byte arriving on the expiry cycle wins
        exp_tx.push_back(8'h06);
        push_cmd(8'h10, 4'd0, 64'h0);
        seq = '{8'hA5, 8'h10};
        send_seq();
        repeat (4998) @(posedge CLK);
        send_byte(8'h00);
        send_byte(8'h10);
        settle("tmo_race");

        // Back-pressure
        CMD_READY = 1'b0;
        exp_tx.push_back(8'h06);
        push_cmd(8'h44, 4'd3, 64'h030201);
        seq = '{8'hA5, 8'h44, 8'h03, 8'h01, 8'h02, 8'h03, 8'h47};
        send_seq();
        vcnt = 0;
        rcnt = 0;
        dcnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (CMD_VALID) vcnt++;
            if (RX_TRIGGER) rcnt++;
            if (CMD_OPCODE !== 8'h44 || CMD_LEN !== 4'd3 || CMD_PAYLOAD !== 64'h030201) dcnt++;
        end
        chk("bp_valid_cycles", 64'(vcnt), 64'd200);
        chk("bp_rxt_cycles", 64'(rcnt), 64'd0);
        chk("bp_data_changes", 64'(dcnt), 64'd0);
        @(posedge CLK);
        #1 CMD_READY = 1'b1;
        settle("backpressure");
        chk("bp_rxt_after", {63'h0, RX_TRIGGER}, 64'd1);

        // Reset mid-payload
        seq = '{8'hA5, 8'h55, 8'h04, 8'hAA, 8'hBB};
        send_seq();
        @(posedge CLK);
        #1 RST = 1'b1;
        exp_err = 0;
        @(negedge CLK);
        reset_checks("midrst");
        @(posedge CLK);
        #1 RST = 1'b0;
        repeat (3) @(posedge CLK);
        exp_tx.push_back(8'h06);
        push_cmd(8'h66, 4'd1, 64'h99);
        seq = '{8'hA5, 8'h66, 8'h01, 8'h99, 8'hFE};
        send_seq();
        settle("post_reset");

        // Saturation
        for (int k = 0; k < 260; k++) begin
            int n;
            exp_tx.push_back(8'h15);
            add_err();
            seq = '{8'hA5, 8'h10, 8'h09};
            send_seq();
            n = 0;
            while (exp_tx.size() != 0 && n < 100) begin
                @(negedge CLK);
                n++;
            end
            repeat (20) @(negedge CLK);
        end
        settle("saturate");
        chk("saturate_255", {56'h0, ERR_COUNT}, 64'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
Command framer sitting directly downstream of the uart block's receiver. It consumes the UART's received bytes, hunts for a sync byte, assembles a framed command (opcode, length, payload, checksum) and hands it to the tester core over a valid/ready interface. It answers each frame with an ACK or NAK byte through the uart's transmit side, and counts framing errors.

Parameters:
MAX_PAYLOAD, 8, maximum payload bytes per frame (1..15).
SYNC_BYTE, 8'hA5, frame start marker.
ACK_BYTE, 8'h06, response byte for a good frame.
NAK_BYTE, 8'h15, response byte for a bad frame.
TIMEOUT_CYCLES, 2_000_000, inter-byte timeout in CLK cycles (>=2).

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
RX_DONE  in  1  one-cycle pulse from uart; RX_BUFFER valid that cycle
RX_BUFFER  in  8  received byte
RX_TRIGGER  out  1  receive enable to uart; high only while framer accepts bytes
TX_DONE  in  1  one-cycle pulse from uart when a byte has finished sending
TX_TRIGGER  out  1  one-cycle pulse starting transmission of TX_BUFFER
TX_BUFFER  out  8  response byte; stable from TX_TRIGGER until TX_DONE
CMD_VALID  out  1  command available
CMD_READY  in  1  core accepts command when CMD_VALID && CMD_READY
CMD_OPCODE  out  8  command opcode
CMD_LEN  out  4  payload byte count
CMD_PAYLOAD  out  8*MAX_PAYLOAD  byte i at [8i+7:8i]; bytes >= CMD_LEN are zero
ERR_COUNT  out  8  saturating error counter

Behaviour:
- Frame format: SYNC_BYTE, OPCODE, LEN, LEN payload bytes, CHK. CHK is the XOR of OPCODE, LEN and all payload bytes.
- Reset values: all outputs 0. State is IDLE, checksum accumulator 0, timeout counter 0.
- States: IDLE, OPC, LEN, PAY, CHK, RESP, HOLD.
- RX_TRIGGER=1 in IDLE, OPC, LEN, PAY and CHK; 0 in RESP and HOLD. An RX_DONE pulse while RX_TRIGGER=0 is ignored.
- Transitions on RX_DONE:
  - IDLE: a byte equal to SYNC_BYTE goes to OPC, clears CMD_PAYLOAD and the accumulator. Any other byte is discarded; stay in IDLE.
  - OPC: latch CMD_OPCODE, go to LEN.
  - LEN > MAX_PAYLOAD: respond NAK.
  - LEN == 0: go to CHK.
  - Otherwise: latch CMD_LEN, go to PAY.
  - PAY: store the byte at the payload index. After the LEN-th byte go to CHK.
  - CHK: if the byte equals the accumulator, set CMD_VALID and respond ACK. Otherwise respond NAK.
- Response: entering RESP loads TX_BUFFER and pulses TX_TRIGGER exactly one cycle, on the first RESP cycle. Stay in RESP until TX_DONE.
  - After an ACK, go to HOLD if CMD_VALID is still set, else IDLE.
  - After a NAK, go to IDLE.
- CMD_VALID:
  - Rises the cycle after the CHK byte's RX_DONE.
  - Clears the cycle after the CMD_VALID && CMD_READY handshake; the handshake may complete during RESP.
  - CMD_OPCODE, CMD_LEN and CMD_PAYLOAD are stable while CMD_VALID=1.
- HOLD: go to IDLE the cycle after the handshake.
- Latency: CHK byte RX_DONE to TX_TRIGGER is 1 cycle.
- Timeout:
  - In OPC, LEN, PAY and CHK a counter increments each cycle and resets on RX_DONE.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, ERR_COUNT+1, no response byte is sent.
  - RX_DONE in the same cycle as the timeout: the byte wins and no timeout occurs.
- ERR_COUNT increments once per NAK or timeout, saturates at 255, and is cleared only by RST.
- A NAK caused by a bad LEN is sent immediately; the remaining bytes of that frame arrive while RX_TRIGGER=0 or are hunted through as non-sync in IDLE.
- RST mid-operation: everything returns to reset values immediately. A partially received frame is dropped and no response is sent.

Optional Feature:
UART_FRAME_CRC8_EN:
- Defined: CHK is CRC-8, polynomial 0x07, init 0x00, MSB-first, no final XOR, computed over OPCODE, LEN and payload. One byte is folded per RX_DONE, bit-serial unrolled combinationally.
- Undefined: CHK is the XOR checksum. No CRC logic is present.
- Everything else is identical in both builds.

Test Plan (XOR build, MAX_PAYLOAD=8, TIMEOUT_CYCLES=5000 unless stated):
- Good frame: bytes A5 10 02 11 22 21, CMD_READY=1 -> CMD_VALID for 1 cycle with CMD_OPCODE=0x10, CMD_LEN=2, CMD_PAYLOAD[15:0]=0x2211 and upper bytes 0; TX_BUFFER=0x06 with one TX_TRIGGER pulse; ERR_COUNT=0.
- Bad checksum: A5 10 02 11 22 20 -> TX_BUFFER=0x15, CMD_VALID never asserts, ERR_COUNT=1. A following good frame is accepted.
- Zero-length frame with leading garbage: 00 FF 33 A5 33 00 33 -> junk ignored; CMD_OPCODE=0x33, CMD_LEN=0, ACK sent.
- Oversize and timeout:
  - A5 10 09 -> NAK right after the LEN byte, ERR_COUNT=1.
  - Then A5 10 followed by 5000 idle cycles -> return to IDLE, no TX_TRIGGER, ERR_COUNT=2.
  - RX_DONE at exactly cycle 5000 -> no timeout.
- Back-pressure: good frame with CMD_READY=0 for 200 cycles -> CMD_VALID and its data held stable, RX_TRIGGER=0 throughout; handshake then returns to IDLE with RX_TRIGGER=1.
- Reset and saturation:
  - RST pulsed mid-payload -> all outputs 0, no TX_TRIGGER; next frame is decoded correctly.
  - 260 bad frames -> ERR_COUNT=255.
